// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
//   Initiator-side sequencer for the 2-bit, 8-op ALU (C,S,A,B -> F).
//   It accepts a command over valid/ready and drives the ALU inputs. It forces
//   a C/S transition, waits a settle window and then captures F. The captured
//   F is returned over valid/ready together with a comparison against an
//   internal golden model. Mismatches are counted in a saturating counter.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready command handshake (cmd_ready is high only in IDLE)
//   cmd_op          {C,S[1:0]} opcode
//   cmd_a, cmd_b    operands
//   alu_c/s/a/b     registered drive to the ALU
//   alu_f           ALU result (DW+1 bits)
//   rsp_valid/ready response handshake
//   rsp_f, rsp_op   captured F and the opcode that produced it
//   rsp_mismatch    captured F differed from the golden value
//   err_cnt         saturating mismatch count

module alu_cmd_driver #(
    parameter int unsigned DW     = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [DW-1:0]   cmd_a,
    input  logic [DW-1:0]   cmd_b,
    output logic            alu_c,
    output logic [1:0]      alu_s,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    input  logic [DW:0]     alu_f,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW:0]     rsp_f,
    output logic [2:0]      rsp_op,
    output logic            rsp_mismatch,
    output logic [CNTW-1:0] err_cnt
);

    localparam int unsigned FW = DW + 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t state, state_nxt;

    // Latched command and settle counter
    logic [2:0]    op_q,  op_nxt;
    logic [DW-1:0] a_q,   a_nxt;
    logic [DW-1:0] b_q,   b_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;

    // Next values of the registered outputs
    logic            cmd_ready_nxt;
    logic            alu_c_nxt;
    logic [1:0]      alu_s_nxt;
    logic [DW-1:0]   alu_a_nxt;
    logic [DW-1:0]   alu_b_nxt;
    logic            rsp_valid_nxt;
    logic [FW-1:0]   rsp_f_nxt;
    logic [2:0]      rsp_op_nxt;
    logic            rsp_mm_nxt;
    logic [CNTW-1:0] err_nxt;

    logic [FW-1:0]   gold_c;
    logic            mismatch_c;

    // Golden ALU model on the latched command; operands are zero-extended
    // and all arithmetic wraps modulo 2^FW.
    always_comb begin
        logic [FW-1:0] ax;
        logic [FW-1:0] bx;
        ax = FW'(a_q);
        bx = FW'(b_q);
        gold_c = '0;
        case (op_q)
            3'b000:  gold_c = ax;
            3'b001:  gold_c = ax & bx;
            3'b010:  gold_c = ax | bx;
            3'b011:  gold_c = ~ax;
            3'b100:  gold_c = ax + bx;
            3'b101:  gold_c = ax - bx;
            3'b110:  gold_c = ax + FW'(1);
            default: gold_c = ax - FW'(1);
        endcase
    end

    assign mismatch_c = (alu_f != gold_c);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid && cmd_ready) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_nxt = S_RESP;
            S_RESP:  if (rsp_valid && rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next-value logic; everything holds unless the state acts on it
    always_comb begin
        op_nxt     = op_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        cnt_nxt    = cnt_q;
        alu_c_nxt  = alu_c;
        alu_s_nxt  = alu_s;
        alu_a_nxt  = alu_a;
        alu_b_nxt  = alu_b;
        rsp_f_nxt  = rsp_f;
        rsp_op_nxt = rsp_op;
        rsp_mm_nxt = rsp_mismatch;
        err_nxt    = err_cnt;
        // cmd_ready/rsp_valid are registered images of the upcoming state
        cmd_ready_nxt = (state_nxt == S_IDLE);
        rsp_valid_nxt = (state_nxt == S_RESP);

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt = cmd_op;
                    a_nxt  = cmd_a;
                    b_nxt  = cmd_b;
                end
            end
            S_SETUP: begin
                // The ALU only re-evaluates on a C/S change. Drive the opcode
                // with S[0] flipped first so the ISSUE step always produces one.
                alu_a_nxt                = a_q;
                alu_b_nxt                = b_q;
                {alu_c_nxt, alu_s_nxt}   = op_q ^ 3'b001;
            end
            S_ISSUE: begin
                {alu_c_nxt, alu_s_nxt} = op_q;
                cnt_nxt                = CW'(SETTLE - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_f_nxt  = alu_f;
                    rsp_op_nxt = op_q;
                    rsp_mm_nxt = mismatch_c;
                    // Saturating count: never wraps past all-ones
                    if (mismatch_c && (err_cnt != {CNTW{1'b1}})) begin
                        err_nxt = err_cnt + CNTW'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            cmd_ready    <= 1'b0;
            alu_c        <= 1'b0;
            alu_s        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_f        <= '0;
            rsp_op       <= '0;
            rsp_mismatch <= 1'b0;
            err_cnt      <= '0;
        end else begin
            op_q         <= op_nxt;
            a_q          <= a_nxt;
            b_q          <= b_nxt;
            cnt_q        <= cnt_nxt;
            cmd_ready    <= cmd_ready_nxt;
            alu_c        <= alu_c_nxt;
            alu_s        <= alu_s_nxt;
            alu_a        <= alu_a_nxt;
            alu_b        <= alu_b_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_f        <= rsp_f_nxt;
            rsp_op       <= rsp_op_nxt;
            rsp_mismatch <= rsp_mm_nxt;
            err_cnt      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU that only
// re-evaluates on C/S changes and can be forced to return 0.
module tb_alu_cmd_driver;

    localparam int unsigned DW   = 2;
    localparam int unsigned CNTW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = '0;
    logic [DW-1:0]   cmd_a = '0;
    logic [DW-1:0]   cmd_b = '0;
    logic            alu_c;
    logic [1:0]      alu_s;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW:0]     alu_f;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW:0]     rsp_f;
    logic [2:0]      rsp_op;
    logic            rsp_mismatch;
    logic [CNTW-1:0] err_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        fault    = 1'b0;
    int unsigned exp_err  = 0;
    logic [DW:0] alu_out  = '0;

    alu_cmd_driver #(.DW(DW), .SETTLE(1), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_c        (alu_c),
        .alu_s        (alu_s),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_f        (rsp_f),
        .rsp_op       (rsp_op),
        .rsp_mismatch (rsp_mismatch),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Board ALU: latches a new result only when C or S changes
    always @(alu_c or alu_s) begin
        case ({alu_c, alu_s})
            3'b000:  alu_out = {1'b0, alu_a};
            3'b001:  alu_out = {1'b0, alu_a & alu_b};
            3'b010:  alu_out = {1'b0, alu_a | alu_b};
            3'b011:  alu_out = ~{1'b0, alu_a};
            3'b100:  alu_out = {1'b0, alu_a} + {1'b0, alu_b};
            3'b101:  alu_out = {1'b0, alu_a} - {1'b0, alu_b};
            3'b110:  alu_out = {1'b0, alu_a} + 3'd1;
            default: alu_out = {1'b0, alu_a} - 3'd1;
        endcase
    end

    assign alu_f = fault ? '0 : alu_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with cmd_ready high or after a bound
    task automatic wait_ready();
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // One full command: accept, SETUP/ISSUE drive, response after 3 edges, optional stall, pop
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                           input logic [2:0] exp_f, input logic exp_mm, input int hold);
        wait_ready();
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("e1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("e1_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("setup_cs", 32'({alu_c, alu_s}), 32'(op ^ 3'b001));
        check("setup_a", 32'(alu_a), 32'(a));
        check("setup_b", 32'(alu_b), 32'(b));
        check("e2_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("issue_cs", 32'({alu_c, alu_s}), 32'(op));
        check("e3_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_f", 32'(rsp_f), 32'(exp_f));
        check("rsp_op", 32'(rsp_op), 32'(op));
        check("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_mm));
        check("err_cnt", 32'(err_cnt), exp_err);
        check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = ~op;
            cmd_a     = ~a;
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_f", 32'(rsp_f), 32'(exp_f));
            check("hold_rsp_op", 32'(rsp_op), 32'(op));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("pop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("pop_cmd_ready", 32'(cmd_ready), 32'd1);
        check("pop_rsp_f_held", 32'(rsp_f), 32'(exp_f));
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset_outputs",
              32'({cmd_ready, alu_c, alu_s, alu_a, alu_b, rsp_valid, rsp_f, rsp_op, rsp_mismatch, err_cnt}),
              32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // Basic arithmetic and wrap cases
        run_cmd(3'b100, 2'd3, 2'd2, 3'b101, 1'b0, 0);
        run_cmd(3'b101, 2'd1, 2'd2, 3'b111, 1'b0, 0);
        run_cmd(3'b111, 2'd0, 2'd0, 3'b111, 1'b0, 0);
        run_cmd(3'b011, 2'd1, 2'd0, 3'b110, 1'b0, 0);

        // Back-to-back identical commands still see a C/S event
        run_cmd(3'b001, 2'd3, 2'd1, 3'b001, 1'b0, 0);
        run_cmd(3'b001, 2'd3, 2'd1, 3'b001, 1'b0, 0);

        // Consumer stalls in RESP while the source keeps offering a command
        run_cmd(3'b000, 2'd2, 2'd1, 3'b010, 1'b0, 5);
        run_cmd(3'b010, 2'd1, 2'd2, 3'b011, 1'b0, 0);

        // Faulty ALU: count mismatches up to saturation
        fault = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_err < 255) exp_err++;
            run_cmd(3'b010, 2'd1, 2'd2, 3'b000, 1'b1, 0);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        fault = 1'b0;
        run_cmd(3'b010, 2'd1, 2'd2, 3'b011, 1'b0, 0);

        // Reset while in WAIT drops the in-flight command
        wait_ready();
        cmd_op    = 3'b101;
        cmd_a     = 2'd1;
        cmd_b     = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_outputs",
              32'({cmd_ready, alu_c, alu_s, alu_a, alu_b, rsp_valid, rsp_f, rsp_op, rsp_mismatch}),
              32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(3'b110, 2'd3, 2'd0, 3'b100, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
